// File: rtl/afe2256_lvds_pkg.sv
// Shared types and defaults for the AFE2256 LVDS receive path.
// Covers the alignment sequencer's state encoding and timing constants.
package afe2256_lvds_pkg;

  typedef enum logic [2:0] {
    AS_IDLE,
    AS_CHECK,
    AS_RESET_CH,
    AS_SETTLE,
    AS_WAIT_ALIGN,
    AS_NEXT,
    AS_FINISH,
    AS_MONITOR
  } align_seq_state_t;

  localparam int ALIGN_RST_CYC     = 8;
  localparam int ALIGN_SETTLE_CYC  = 64;
  localparam int ALIGN_TIMEOUT_CYC = 20000;
  localparam int ALIGN_MAX_RETRY   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/afe2256_sync2.sv
// Two-flop synchronizer for quasi-static status bits crossing into clk_sys.
module afe2256_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/afe2256_align_sequencer.sv
// Per-channel LVDS bit-alignment sequencer: reset, settle, wait for alignment
// with timeout and bounded retries, then monitor aligned channels for loss.
//
// state         | meaning
// AS_IDLE       | waiting for start
// AS_CHECK      | skip disabled channel or begin its reset pulse
// AS_RESET_CH   | deserializer reset of cur_ch held low
// AS_SETTLE     | reset released, letting the deserializer settle
// AS_WAIT_ALIGN | waiting for bit_aligned, error, or timeout
// AS_NEXT       | advance to the next channel
// AS_FINISH     | done pulse, all_aligned latched
// AS_MONITOR    | watching aligned channels for loss of alignment
module afe2256_align_sequencer
  import afe2256_lvds_pkg::*;
#(
  parameter int N_CH        = 14,
  parameter int RST_CYC     = ALIGN_RST_CYC,
  parameter int SETTLE_CYC  = ALIGN_SETTLE_CYC,
  parameter int TIMEOUT_CYC = ALIGN_TIMEOUT_CYC,
  parameter int MAX_RETRY   = ALIGN_MAX_RETRY,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [N_CH-1:0] ch_enable,
  input  logic [N_CH-1:0] ch_aligned,
  input  logic [N_CH-1:0] ch_error,
  output logic [N_CH-1:0] ch_rst_n,
  output logic            busy,
  output logic            done,
  output logic            all_aligned,
  output logic [N_CH-1:0] fail_mask,
  output logic [N_CH-1:0] lost_mask,
  output logic [CH_W-1:0] cur_ch,
  output logic [RC_W-1:0] retry_cnt
);

  localparam int CNT_W = $clog2(max3(RST_CYC, SETTLE_CYC, TIMEOUT_CYC) + 1);

  localparam logic [CNT_W-1:0] CNT_RST     = CNT_W'(RST_CYC);
  localparam logic [CNT_W-1:0] CNT_SETTLE  = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(N_CH - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(MAX_RETRY);

  align_seq_state_t state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic [N_CH-1:0]  al_s;
  logic [N_CH-1:0]  er_s;
  logic [N_CH-1:0]  lost_now;

  afe2256_sync2 #(.W(N_CH)) u_sync_aligned (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .d       (ch_aligned),
    .q       (al_s)
  );

  afe2256_sync2 #(.W(N_CH)) u_sync_error (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .d       (ch_error),
    .q       (er_s)
  );

  // Counter is loaded with N and the state ends on its Nth cycle.
  assign cnt_tc   = (cnt <= CNT_W'(1));
  assign lost_now = ch_enable & ~fail_mask & ~al_s;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= AS_IDLE;
      cnt         <= '0;
      ch_rst_n    <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
      all_aligned <= 1'b0;
      fail_mask   <= '0;
      lost_mask   <= '0;
      cur_ch      <= '0;
      retry_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != AS_IDLE) begin
        state    <= AS_IDLE;
        ch_rst_n <= '1;
        busy     <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          AS_IDLE, AS_MONITOR: begin
            if (state == AS_MONITOR && |lost_now) begin
              lost_mask   <= lost_mask | lost_now;
              all_aligned <= 1'b0;
            end
            if (start) begin
              fail_mask   <= '0;
              lost_mask   <= '0;
              all_aligned <= 1'b0;
              retry_cnt   <= '0;
              cur_ch      <= '0;
              busy        <= 1'b1;
              state       <= AS_CHECK;
            end
          end
          AS_CHECK: begin
            if (ch_enable[cur_ch]) begin
              cnt              <= CNT_RST;
              ch_rst_n[cur_ch] <= 1'b0;
              state            <= AS_RESET_CH;
            end else begin
              state <= AS_NEXT;
            end
          end
          AS_RESET_CH: begin
            if (cnt_tc) begin
              ch_rst_n[cur_ch] <= 1'b1;
              cnt              <= CNT_SETTLE;
              state            <= AS_SETTLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          AS_SETTLE: begin
            if (cnt_tc) begin
              cnt   <= CNT_TIMEOUT;
              state <= AS_WAIT_ALIGN;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          AS_WAIT_ALIGN: begin
            if (!cnt_tc) cnt <= cnt - CNT_W'(1);
            // Success is checked first so a simultaneous error is ignored.
            if (al_s[cur_ch]) begin
              state <= AS_NEXT;
            end else if (er_s[cur_ch] || cnt_tc) begin
              if (retry_cnt < RETRY_MAX) begin
                retry_cnt        <= retry_cnt + RC_W'(1);
                cnt              <= CNT_RST;
                ch_rst_n[cur_ch] <= 1'b0;
                state            <= AS_RESET_CH;
              end else begin
                fail_mask[cur_ch] <= 1'b1;
                state             <= AS_NEXT;
              end
            end
          end
          AS_NEXT: begin
            retry_cnt <= '0;
            if (cur_ch == LAST_CH) begin
              done        <= 1'b1;
              all_aligned <= (|ch_enable) && ((ch_enable & ~fail_mask) == ch_enable);
              state       <= AS_FINISH;
            end else begin
              cur_ch <= cur_ch + CH_W'(1);
              state  <= AS_CHECK;
            end
          end
          AS_FINISH: begin
            busy  <= 1'b0;
            state <= AS_MONITOR;
          end
          default: state <= AS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_afe2256_align_sequencer.sv
// Bench for afe2256_align_sequencer: behavioural deserializer channels plus a
// scoreboard that checks each done pulse against the expected outcome.
module tb_afe2256_align_sequencer;

  localparam int N_CH        = 4;
  localparam int RST_CYC     = 4;
  localparam int SETTLE_CYC  = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int MAX_RETRY   = 2;

  logic            clk_sys = 1'b0;
  logic            rst_n   = 1'b0;
  logic            start   = 1'b0;
  logic            abort   = 1'b0;
  logic [N_CH-1:0] ch_enable = '0;
  logic [N_CH-1:0] mdl_al    = '0;
  logic [N_CH-1:0] drop_mask = '0;
  logic [N_CH-1:0] ch_error  = '0;
  logic [N_CH-1:0] ch_aligned;
  logic [N_CH-1:0] ch_rst_n;
  logic            busy, done, all_aligned;
  logic [N_CH-1:0] fail_mask, lost_mask;
  logic [1:0]      cur_ch, retry_cnt;

  assign ch_aligned = mdl_al & ~drop_mask;

  afe2256_align_sequencer #(
    .N_CH(N_CH), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .ch_enable   (ch_enable),
    .ch_aligned  (ch_aligned),
    .ch_error    (ch_error),
    .ch_rst_n    (ch_rst_n),
    .busy        (busy),
    .done        (done),
    .all_aligned (all_aligned),
    .fail_mask   (fail_mask),
    .lost_mask   (lost_mask),
    .cur_ch      (cur_ch),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic            aa;
    logic [N_CH-1:0] fm;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // channel model: 0 aligns 5 cycles after release, 1 never aligns,
  // 2 flags an error on the first attempt and aligns afterwards
  int mode[N_CH];
  int rel_cnt[N_CH]  = '{default: -1};
  int pulses[N_CH]   = '{default: 0};
  int low_len[N_CH]  = '{default: 0};
  int high_len[N_CH] = '{default: 0};
  int max_rty[N_CH]  = '{default: 0};
  logic [N_CH-1:0] prev_rst = '1;
  int last_ch = 0;
  bit chk_len = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    #1;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_rst_n[i] === 1'b0) begin
        if (prev_rst[i]) begin
          pulses[i]++;
          if (pulses[i] > 1 && mode[i] == 1)
            check($sformatf("retry_gap_ch%0d", i), 32'(high_len[i]), 32'(SETTLE_CYC + TIMEOUT_CYC));
          check($sformatf("order_ch%0d", i), 32'(i >= last_ch), 32'd1);
          last_ch    = i;
          low_len[i] = 0;
        end
        low_len[i]++;
        mdl_al[i]   = 1'b0;
        ch_error[i] = 1'b0;
        rel_cnt[i]  = -1;
      end else begin
        if (!prev_rst[i]) begin
          if (chk_len) check($sformatf("rst_len_ch%0d", i), 32'(low_len[i]), 32'(RST_CYC));
          rel_cnt[i]  = 0;
          high_len[i] = 0;
        end
        high_len[i]++;
        if (rel_cnt[i] >= 0) begin
          rel_cnt[i]++;
          if (rel_cnt[i] == 5) begin
            if (mode[i] == 0) mdl_al[i] = 1'b1;
            else if (mode[i] == 2) begin
              if (pulses[i] == 1) ch_error[i] = 1'b1;
              else mdl_al[i] = 1'b1;
            end
          end
        end
      end
      prev_rst[i] = (ch_rst_n[i] !== 1'b0);
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk_sys);
    if (busy === 1'b1 && int'(retry_cnt) > max_rty[cur_ch]) max_rty[cur_ch] = int'(retry_cnt);
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no outcome queued at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("done_all_aligned", 32'(all_aligned), 32'(e.aa));
        check("done_fail_mask", 32'(fail_mask), 32'(e.fm));
      end
    end
  end

  task automatic prep(input logic [2*N_CH-1:0] modes);
    for (int i = 0; i < N_CH; i++) begin
      mode[i]    = int'(modes[2*i +: 2]);
      pulses[i]  = 0;
      max_rty[i] = 0;
    end
    last_ch = 0;
  endtask

  task automatic start_seq(input logic [N_CH-1:0] en);
    ch_enable = en;
    @(negedge clk_sys);
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_clears_lost", 32'(lost_mask), 32'd0);
    check("start_clears_fail", 32'(fail_mask), 32'd0);
    check("start_clears_all_aligned", 32'(all_aligned), 32'd0);
    check("start_check_no_rst", 32'(ch_rst_n), 32'hF);
    @(negedge clk_sys);
    if (en[0]) check("ch0_rst_t2", 32'(ch_rst_n[0]), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  function automatic int exp_pulses(input logic en, input int m);
    if (!en) return 0;
    if (m == 1) return 1 + MAX_RETRY;
    if (m == 2) return 2;
    return 1;
  endfunction

  task automatic run_seq(input logic [N_CH-1:0] en, input logic [2*N_CH-1:0] modes,
                         input logic exp_aa, input logic [N_CH-1:0] exp_fm);
    exp_t e;
    prep(modes);
    e.aa = exp_aa;
    e.fm = exp_fm;
    exp_q.push_back(e);
    start_seq(en);
    wait_done(3000);
    @(negedge clk_sys);
    check("busy_after_done", 32'(busy), 32'd0);
    check("retry_cnt_after_done", 32'(retry_cnt), 32'd0);
    for (int i = 0; i < N_CH; i++)
      check($sformatf("pulses_ch%0d", i), 32'(pulses[i]), 32'(exp_pulses(en[i], mode[i])));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ch_rst_n"}, 32'(ch_rst_n), 32'hF);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_all_aligned"}, 32'(all_aligned), 32'd0);
    check({tag, "_fail_mask"}, 32'(fail_mask), 32'd0);
    check({tag, "_lost_mask"}, 32'(lost_mask), 32'd0);
    check({tag, "_cur_ch"}, 32'(cur_ch), 32'd0);
    check({tag, "_retry_cnt"}, 32'(retry_cnt), 32'd0);
  endtask

  initial begin
    int d0;
    prep(8'h00);
    repeat (3) @(negedge clk_sys);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    run_seq(4'b1111, 8'h00, 1'b1, 4'b0000);
    check("s1_lost_clear", 32'(lost_mask), 32'd0);

    run_seq(4'b1010, 8'h00, 1'b1, 4'b0000);

    run_seq(4'b1111, 8'h04, 1'b0, 4'b0010);

    run_seq(4'b1111, 8'h20, 1'b1, 4'b0000);
    check("s4_ch2_max_retry", 32'(max_rty[2]), 32'd1);
    check("s4_ch3_max_retry", 32'(max_rty[3]), 32'd0);

    // loss of alignment in MONITOR, then abort from MONITOR
    check("s5_pre_all_aligned", 32'(all_aligned), 32'd1);
    drop_mask = 4'b1000;
    repeat (3) @(negedge clk_sys);
    check("s5_lost_mask", 32'(lost_mask), 32'h8);
    check("s5_all_aligned_fell", 32'(all_aligned), 32'd0);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    check("s5_abort_busy", 32'(busy), 32'd0);
    check("s5_abort_lost_held", 32'(lost_mask), 32'h8);
    drop_mask = '0;
    run_seq(4'b1111, 8'h00, 1'b1, 4'b0000);

    // abort during RESET_CH of channel 0
    chk_len = 1'b0;
    prep(8'h00);
    d0 = done_cnt;
    start_seq(4'b1111);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    check("s6_abort_ch_rst_n", 32'(ch_rst_n), 32'hF);
    check("s6_abort_busy", 32'(busy), 32'd0);
    check("s6_abort_done", 32'(done), 32'd0);
    repeat (10) @(negedge clk_sys);
    check("s6_no_done", 32'(done_cnt), 32'(d0));
    check("s6_still_idle", 32'(busy), 32'd0);
    chk_len = 1'b1;

    // synchronous reset mid-WAIT_ALIGN of channel 1 after channel 0 failed
    prep(8'h05);
    start_seq(4'b1111);
    repeat (260) @(negedge clk_sys);
    check("s7_pre_busy", 32'(busy), 32'd1);
    check("s7_pre_cur_ch", 32'(cur_ch), 32'd1);
    check("s7_pre_fail_mask", 32'(fail_mask), 32'h1);
    rst_n = 1'b0;
    @(negedge clk_sys);
    check_reset_values("s7_rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("s7_stays_idle", 32'(busy), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/afe2256_align_sequencer.md
# afe2256_align_sequencer

Sequences LVDS bit alignment across all AFE2256 deserializer channels from the system clock domain. One channel at a time, it pulses the channel's deserializer reset, waits for settling, then waits for `bit_aligned`, with a timeout and bounded retries. It records per-channel failures, reports overall alignment, and keeps monitoring aligned channels for loss of alignment. It sits between the readout control/register block and the array of per-channel deserializers.

## Interface
Parameters:
- `N_CH`, 14, number of deserializer channels
- `RST_CYC`, 8, clk_sys cycles the channel reset is held low
- `SETTLE_CYC`, 64, cycles to wait after reset release before watching status
- `TIMEOUT_CYC`, 20000, maximum cycles to wait for alignment per attempt
- `MAX_RETRY`, 3, retries per channel after the first attempt

Ports (one clock; reset is synchronous and active-low):
- `clk_sys`  in  1  system clock, 100 MHz
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  single-cycle request to (re)run the full alignment sequence
- `abort`  in  1  single-cycle request to stop the sequence and return to IDLE
- `ch_enable`  in  N_CH  channels to align; disabled channels are skipped
- `ch_aligned`  in  N_CH  per-channel `bit_aligned` (async to clk_sys)
- `ch_error`  in  N_CH  per-channel alignment FSM error flag (`error_flags[2]`, async)
- `ch_rst_n`  out  N_CH  per-channel deserializer reset, active-low
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse when the sequence completes
- `all_aligned`  out  1  at least one channel enabled, and every enabled channel aligned, at completion
- `fail_mask`  out  N_CH  channels that exhausted retries
- `lost_mask`  out  N_CH  sticky: channel lost alignment while in MONITOR
- `cur_ch`  out  $clog2(N_CH)  channel currently being processed
- `retry_cnt`  out  $clog2(MAX_RETRY+1)  retries used on `cur_ch`

## Operation
- `ch_aligned` and `ch_error` pass through 2-flop synchronizers. All decisions use the synchronized values `al_s` and `er_s`.
- FSM states: IDLE, CHECK, RESET_CH, SETTLE, WAIT_ALIGN, NEXT, FINISH, MONITOR.
- IDLE or MONITOR with `start`:
  - clear `fail_mask`, `lost_mask`, `all_aligned`, `retry_cnt`
  - set `cur_ch`=0
  - go to CHECK
- CHECK: if `ch_enable[cur_ch]`, load the counter with RST_CYC and go to RESET_CH; otherwise go to NEXT.
- RESET_CH: `ch_rst_n[cur_ch]`=0. When the counter expires, release the reset, load SETTLE_CYC and go to SETTLE.
- SETTLE: count down, then load TIMEOUT_CYC and go to WAIT_ALIGN.
- WAIT_ALIGN, evaluated in priority order:
  1. `al_s[cur_ch]` → NEXT (success).
  2. `er_s[cur_ch]` or timeout expiry → retry: if `retry_cnt` < MAX_RETRY, increment it and go to RESET_CH with RST_CYC loaded.
  3. Otherwise set `fail_mask[cur_ch]` and go to NEXT.
- NEXT: clear `retry_cnt`. If `cur_ch`==N_CH-1, go to FINISH; otherwise increment `cur_ch` and go to CHECK.
- FINISH:
  - `done`=1 for this cycle
  - `all_aligned` = (`ch_enable`≠0) & ((`ch_enable` & ~`fail_mask`) == `ch_enable`)
  - go to MONITOR
- MONITOR: each cycle, `lost_mask` |= `ch_enable` & ~`fail_mask` & ~`al_s`. Any bit set clears `all_aligned`. There is no automatic realign.
- `abort` in any state except IDLE:
  - go to IDLE next cycle
  - all `ch_rst_n` go to 1
  - `fail_mask` and `lost_mask` hold their values
  - no `done` pulse
- `abort` takes priority over `start`. `start` while in a busy state is ignored.

## Timing
- Reset values:
  - `ch_rst_n` all 1
  - `busy`, `done`, `all_aligned` = 0
  - `fail_mask`, `lost_mask`, `cur_ch`, `retry_cnt` = 0
  - state IDLE; counter 0
- All outputs are registered.
- `busy`=1 in CHECK, RESET_CH, SETTLE, WAIT_ALIGN, NEXT and FINISH.
- `start` at cycle t → CHECK at t+1 → `ch_rst_n[0]` low from t+2 for exactly RST_CYC cycles (if channel 0 is enabled).
- Status latency is 2 cycles (synchronizer) plus 1 cycle (FSM decision).
- An enabled channel that succeeds on its first attempt costs 1+RST_CYC+SETTLE_CYC+k+1 cycles, where k is the WAIT_ALIGN dwell in cycles (k≥1).
- A disabled channel costs 2 cycles.
- A timeout fires after exactly TIMEOUT_CYC WAIT_ALIGN cycles.
- Within WAIT_ALIGN, a same-cycle `al_s` and `er_s`: success wins.
- Reset during any state: the next cycle returns to IDLE with all reset values.

## Structure
- Add to `afe2256_lvds_pkg`:
  - `align_seq_state_t` enum
  - default constants `ALIGN_RST_CYC`, `ALIGN_SETTLE_CYC`, `ALIGN_TIMEOUT_CYC`, `ALIGN_MAX_RETRY`
- Sub-module `afe2256_sync2`: parameterized-width 2-flop synchronizer with synchronous active-low reset. Instantiate it twice (aligned, error).
- The counter is shared across states, width $clog2(max(RST_CYC, SETTLE_CYC, TIMEOUT_CYC)+1).

## Test plan
Parameters for all scenarios: N_CH=4, RST_CYC=4, SETTLE_CYC=8, TIMEOUT_CYC=64, MAX_RETRY=2.
- All enabled, each `ch_aligned` rises 5 cycles after its reset release → `ch_rst_n[i]` low for 4 cycles, in channel order; one `done` pulse; `all_aligned`=1, `fail_mask`=0.
- `ch_enable`=4'b1010 → channels 0 and 2 are never reset; `done` with `all_aligned`=1.
- Channel 1 never aligns → 3 reset pulses on ch1, each WAIT_ALIGN lasting 64 cycles; `fail_mask`=4'b0010, `all_aligned`=0.
- Channel 2 asserts `ch_error` on the first attempt and aligns on the second → `retry_cnt` reaches 1 then clears; `fail_mask`=0.
- In MONITOR, drop `ch_aligned[3]` → `lost_mask`=4'b1000 within 3 cycles and `all_aligned` falls; then `start` clears both and re-runs.
- `abort` during RESET_CH of ch0 → IDLE next cycle, all `ch_rst_n`=1, `busy`=0, no `done`. Separately, `rst_n` low mid-WAIT_ALIGN → all outputs return to their reset values.
